// File: rtl/mult_pkg.sv
// Shared types and constants for the partial-product multiplier family.
package mult_pkg;

    localparam int unsigned N_DEF  = 8;
    localparam int unsigned PROD_W = 2 * N_DEF;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} acc_state_t;

    function automatic logic [N_DEF-1:0] row_of(input logic [N_DEF*N_DEF-1:0] pp,
                                                 input int unsigned i);
        return N_DEF'(pp >> (i * N_DEF));
    endfunction

endpackage

// File: rtl/pp_row_adder.sv
// Adds ROWS_PER_CYCLE consecutive partial-product rows, starting at base, onto the accumulator.
module pp_row_adder
    import mult_pkg::*;
#(
    parameter int unsigned N              = N_DEF,
    parameter int unsigned ROWS_PER_CYCLE = 1,
    parameter int unsigned RW             = $clog2(N) + 1
) (
    input  logic [N*N-1:0] pp,
    input  logic [RW-1:0]  base,
    input  logic [2*N-1:0] acc_in,
    output logic [2*N-1:0] acc_out
);

    logic [2*N-1:0] terms [ROWS_PER_CYCLE];

    for (genvar k = 0; k < ROWS_PER_CYCLE; k++) begin : g_row
        logic [RW:0]  idx;
        logic [N-1:0] row;

        assign idx = {1'b0, base} + (RW+1)'(k);

        // Shift-based select yields zero for rows past N-1 instead of an out-of-range slice.
        if (N == N_DEF) begin : g_pkg
            assign row = row_of(pp, 32'(idx));
        end else begin : g_gen
            assign row = N'(pp >> (32'(idx) * N));
        end

        assign terms[k] = {{N{1'b0}}, row} << idx;
    end

    always_comb begin
        acc_out = acc_in;
        for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
            acc_out = acc_out + terms[k];
        end
    end

endmodule

// File: rtl/pp_seq_accumulator.sv
// Sequential shift-add reducer: captures an N*N partial-product array and folds
// ROWS_PER_CYCLE rows per clock into a 2N-bit product with valid/ready on both sides.
module pp_seq_accumulator
    import mult_pkg::*;
#(
    parameter int unsigned N              = N_DEF,
    parameter int unsigned ROWS_PER_CYCLE = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*N-1:0] PP,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [2*N-1:0] P,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy
);

    localparam int unsigned RW = $clog2(N) + 1;
    localparam logic [RW-1:0] STEP     = RW'(ROWS_PER_CYCLE);
    localparam logic [RW-1:0] LAST_ROW = RW'(N);

    if (((ROWS_PER_CYCLE == 0) ? 1 : (N % ROWS_PER_CYCLE)) != 0) begin : g_bad_rows
        $error("ROWS_PER_CYCLE (%0d) must evenly divide N (%0d)", ROWS_PER_CYCLE, N);
    end

    acc_state_t     state_q;
    logic [N*N-1:0] pp_q;
    logic [2*N-1:0] acc_q;
    logic [2*N-1:0] acc_nxt;
    logic [RW-1:0]  row_q;
    logic [RW-1:0]  row_nxt;

    assign row_nxt = row_q + STEP;

    pp_row_adder #(
        .N              (N),
        .ROWS_PER_CYCLE (ROWS_PER_CYCLE),
        .RW             (RW)
    ) u_row_adder (
        .pp      (pp_q),
        .base    (row_q),
        .acc_in  (acc_q),
        .acc_out (acc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pp_q      <= '0;
            acc_q     <= '0;
            row_q     <= '0;
            P         <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        pp_q     <= PP;
                        acc_q    <= '0;
                        row_q    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_nxt;
                    row_q <= row_nxt;
                    if (row_nxt == LAST_ROW) begin
                        P         <= acc_nxt;
                        out_valid <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    // in_ready stays low here, so a waiting PP is only taken once back in IDLE.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule
